// File: rtl/act_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one sigmoid/inverse-sigmoid unit between two requesters.
// Result valid LAT+2 cycles after the request is sampled; held until the owner acks.
module act_arbiter #(
  parameter int LAT = 2
) (
  input  logic        CLOCK_50,
  input  logic        Reset,
  input  logic [1:0]  req,
  input  logic [1:0]  op_sel,
  input  logic [31:0] x0,
  input  logic [31:0] x1,
  output logic [1:0]  gnt,
  output logic [31:0] au_x,
  output logic        au_sel,
  output logic        au_start,
  input  logic [31:0] sig_y,
  input  logic [31:0] isig_y,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_data,
  input  logic [1:0]  rsp_ack,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t     state;
  state_t     state_nxt;
  logic       owner;
  logic       rr;
  logic       win;
  logic [3:0] cnt;
  logic [1:0] owner_vec;

  // On a tie the requester that was not served last wins.
  assign win       = (req == 2'b11) ? ~rr : req[1];
  assign owner_vec = {owner, ~owner};

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt       = 2'b00;
    au_start  = 1'b0;
    rsp_valid = 2'b00;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (req != 2'b00) state_nxt = ISSUE;
      end
      ISSUE: begin
        gnt       = owner_vec;
        au_start  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = owner_vec;
        if (rsp_ack[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      owner    <= 1'b0;
      rr       <= 1'b1;
      cnt      <= 4'd0;
      au_x     <= 32'd0;
      au_sel   <= 1'b0;
      rsp_data <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner  <= win;
            au_x   <= win ? x1 : x0;
            au_sel <= op_sel[win];
          end
        end
        ISSUE: cnt <= CNT_LOAD;
        WAIT: begin
          if (cnt == 4'd0) begin
            rsp_data <= au_sel ? isig_y : sig_y;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ack[owner]) rr <= owner;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_act_arbiter.sv
`timescale 1ns/1ps
// Bench for act_arbiter: directed vectors, corner sequences, LAT=1/15 builds,
// and randomized traffic against a transaction-timeline reference model.
module tb_act_arbiter;
  localparam int LM = 2;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, op_sel, rsp_ack;
  logic [31:0] x0, x1;
  logic [31:0] sig_y, isig_y;
  logic [1:0]  gnt, rsp_valid;
  logic [31:0] au_x, rsp_data;
  logic        au_sel, au_start, busy;

  logic [1:0]  req_b, ack_b, gnt_b, valid_b;
  logic [31:0] au_x_b, data_b;
  logic        sel_b, start_b, busy_b;
  logic [1:0]  req_c, ack_c, gnt_c, valid_c;
  logic [31:0] au_x_c, data_c;
  logic        sel_c, start_c, busy_c;
  logic [31:0] sig_k, isig_k;

  int total = 0;
  int bad   = 0;

  act_arbiter #(.LAT(LM)) dut (
    .CLOCK_50(clk), .Reset(rst), .req(req), .op_sel(op_sel), .x0(x0), .x1(x1),
    .gnt(gnt), .au_x(au_x), .au_sel(au_sel), .au_start(au_start),
    .sig_y(sig_y), .isig_y(isig_y), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ack(rsp_ack), .busy(busy));

  act_arbiter #(.LAT(1)) dut_b (
    .CLOCK_50(clk), .Reset(rst), .req(req_b), .op_sel(op_sel), .x0(x0), .x1(x1),
    .gnt(gnt_b), .au_x(au_x_b), .au_sel(sel_b), .au_start(start_b),
    .sig_y(sig_k), .isig_y(isig_k), .rsp_valid(valid_b), .rsp_data(data_b),
    .rsp_ack(ack_b), .busy(busy_b));

  act_arbiter #(.LAT(15)) dut_c (
    .CLOCK_50(clk), .Reset(rst), .req(req_c), .op_sel(op_sel), .x0(x0), .x1(x1),
    .gnt(gnt_c), .au_x(au_x_c), .au_sel(sel_c), .au_start(start_c),
    .sig_y(sig_k), .isig_y(isig_k), .rsp_valid(valid_c), .rsp_data(data_c),
    .rsp_ack(ack_c), .busy(busy_c));

  function automatic logic [31:0] f_sig(input logic [31:0] x);
    return x + 32'h3F00_0000;
  endfunction
  function automatic logic [31:0] f_isig(input logic [31:0] x);
    return x - 32'h3F00_0000;
  endfunction

  // Activation unit: result only valid exactly LM cycles after the start pulse.
  int          age = 0;
  logic [31:0] ux  = 32'd0;
  always @(posedge clk) begin
    if (au_start) begin
      age <= 1;
      ux  <= au_x;
    end else if (age > 0 && age < 1000) begin
      age <= age + 1;
    end
  end
  assign sig_y  = (age == LM) ? f_sig(ux)  : 32'hDEAD_BEEF;
  assign isig_y = (age == LM) ? f_isig(ux) : 32'hBAD0_0BAD;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req = 2'b00;
    for (int c = 0; c < 40 && busy; c++) begin
      rsp_ack = rsp_valid;
      tick();
    end
    rsp_ack = 2'b00;
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [1:0]  r;
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  g;
    logic [31:0] ax;
    logic        sel;
    logic [31:0] d;
    int          hold;
  } vec_t;

  task automatic run_vec(input vec_t v);
    req = v.r; op_sel = v.s; x0 = v.a; x1 = v.b;
    tick();
    req = 2'b00; op_sel = ~v.s; x0 = ~v.a; x1 = ~v.b;
    chk("v_gnt", 32'(gnt), 32'(v.g));
    chk("v_start", 32'(au_start), 32'd1);
    chk("v_au_x", au_x, v.ax);
    chk("v_au_sel", 32'(au_sel), 32'(v.sel));
    for (int c = 0; c < LM; c++) begin
      tick();
      chk("v_wait_valid", 32'(rsp_valid), 32'd0);
      chk("v_wait_gnt", 32'(gnt), 32'd0);
      chk("v_wait_au_x", au_x, v.ax);
    end
    tick();
    chk("v_valid", 32'(rsp_valid), 32'(v.g));
    chk("v_data", rsp_data, v.d);
    for (int c = 0; c < v.hold; c++) begin
      rsp_ack = ~v.g;
      tick();
      chk("v_hold_valid", 32'(rsp_valid), 32'(v.g));
      chk("v_hold_data", rsp_data, v.d);
      chk("v_hold_gnt", 32'(gnt), 32'd0);
    end
    rsp_ack = v.g;
    tick();
    rsp_ack = 2'b00;
    chk("v_ack_valid", 32'(rsp_valid), 32'd0);
    chk("v_ack_busy", 32'(busy), 32'd0);
  endtask

  // Reference model: position in the transaction timeline, not an FSM.
  logic        mb, mo, mrr, msel;
  int          mt;
  logic [31:0] mx, mdata;

  task automatic model_step(input logic r_rst, input logic [1:0] r, input logic [1:0] s,
                            input logic [31:0] a, input logic [31:0] b, input logic [1:0] ack);
    if (r_rst) begin
      mb = 0; mt = 0; mrr = 1; mx = 0; msel = 0; mdata = 0; mo = 0;
    end else if (!mb) begin
      if (r != 2'b00) begin
        if (r == 2'b11) mo = (mrr == 1'b1) ? 1'b0 : 1'b1;
        else            mo = (r == 2'b10);
        mb = 1; mt = 1;
        mx = mo ? b : a;
        msel = s[mo];
      end
    end else if (mt >= LM + 2) begin
      if (ack[mo]) begin
        mb = 0; mrr = mo;
      end
    end else begin
      mt++;
      if (mt == LM + 2) mdata = msel ? f_isig(mx) : f_sig(mx);
    end
  endtask

  vec_t       tv[5];
  vec_t       vx;
  logic [1:0] order[4];
  logic [1:0] pend, eg, ev;
  int         ng, lastc, fb, fc;

  initial begin
    tv[0] = '{2'b01, 2'b00, 32'h0000_0000, 32'h0000_0005, 2'b01, 32'h0000_0000, 1'b0, 32'h3F00_0000, 3};
    tv[1] = '{2'b10, 2'b10, 32'h0000_0007, 32'h3F00_0000, 2'b10, 32'h3F00_0000, 1'b1, 32'h0000_0000, 2};
    tv[2] = '{2'b11, 2'b01, 32'h3F80_0000, 32'h0000_0001, 2'b01, 32'h3F80_0000, 1'b1, 32'h0080_0000, 0};
    tv[3] = '{2'b11, 2'b10, 32'h0000_0009, 32'h4000_0000, 2'b10, 32'h4000_0000, 1'b1, 32'h0100_0000, 1};
    tv[4] = '{2'b10, 2'b01, 32'h0000_0003, 32'h1234_5678, 2'b10, 32'h1234_5678, 1'b0, 32'h5134_5678, 0};
    sig_k = 32'h1111_1111; isig_k = 32'h2222_2222;
    rst = 1; req = 0; op_sel = 0; x0 = 0; x1 = 0; rsp_ack = 0;
    req_b = 0; ack_b = 0; req_c = 0; ack_c = 0;
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_start", 32'(au_start), 32'd0);
    chk("rst_au_x", au_x, 32'd0);
    chk("rst_au_sel", 32'(au_sel), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 0;
    tick();

    for (int i = 0; i < 5; i++) run_vec(tv[i]);

    // Fairness with both requests held.
    for (int i = 0; i < 4; i++) order[i] = 2'b00;
    ng = 0; lastc = -1; req = 2'b11;
    for (int c = 1; c <= 200 && (ng < 4 || busy); c++) begin
      tick();
      rsp_ack = rsp_valid;
      if (gnt != 2'b00) begin
        if (ng < 4) order[ng] = gnt;
        if (lastc >= 0) chk("rr_spacing", 32'(c - lastc), 32'(LM + 3));
        lastc = c;
        ng++;
        if (ng == 4) req = 2'b00;
      end
    end
    rsp_ack = 2'b00;
    chk("rr_count", 32'(ng), 32'd4);
    chk("rr_order0", 32'(order[0]), 32'h1);
    chk("rr_order1", 32'(order[1]), 32'h2);
    chk("rr_order2", 32'(order[2]), 32'h1);
    chk("rr_order3", 32'(order[3]), 32'h2);

    // Delayed ack with a competing request pending.
    req = 2'b01; op_sel = 2'b00; x0 = 32'h0000_1000;
    tick();
    chk("dly_gnt0", 32'(gnt), 32'h1);
    req = 2'b10;
    for (int c = 0; c < LM + 1; c++) tick();
    for (int c = 0; c < 10; c++) begin
      chk("dly_valid", 32'(rsp_valid), 32'h1);
      chk("dly_data", rsp_data, 32'h3F00_1000);
      chk("dly_gnt", 32'(gnt), 32'd0);
      x0 = $urandom; rsp_ack = 2'b10;
      tick();
    end
    rsp_ack = 2'b01;
    tick();
    rsp_ack = 2'b00;
    chk("dly_idle_gnt", 32'(gnt), 32'd0);
    chk("dly_idle_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("dly_next_gnt", 32'(gnt), 32'h2);
    drain();

    // Reset in WAIT discards the op and restores the tie-break pointer.
    vx = '{2'b01, 2'b00, 32'h0000_0005, 32'h0, 2'b01, 32'h0000_0005, 1'b0, 32'h3F00_0005, 0};
    run_vec(vx);
    req = 2'b11; x1 = 32'hCAFE_0001; op_sel = 2'b10;
    tick();
    chk("wrst_pre_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("wrst_gnt", 32'(gnt), 32'd0);
    chk("wrst_start", 32'(au_start), 32'd0);
    chk("wrst_au_x", au_x, 32'd0);
    chk("wrst_au_sel", 32'(au_sel), 32'd0);
    chk("wrst_valid", 32'(rsp_valid), 32'd0);
    chk("wrst_data", rsp_data, 32'd0);
    chk("wrst_busy", 32'(busy), 32'd0);
    for (int c = 0; c < LM + 3; c++) begin
      tick();
      chk("wrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    req = 2'b11;
    tick();
    chk("wrst_tie_gnt", 32'(gnt), 32'h1);
    drain();

    // LAT=1 and LAT=15 builds, with stray acks for the non-owner.
    op_sel = 2'b00; req_b = 2'b01; req_c = 2'b01; ack_b = 2'b10; ack_c = 2'b10;
    tick();
    req_b = 2'b00; req_c = 2'b00; fb = -1; fc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (valid_b != 2'b00 && fb < 0) fb = c;
      if (valid_c != 2'b00 && fc < 0) fc = c;
      if (c < 20) tick();
    end
    chk("lat1_cycle", 32'(fb), 32'd3);
    chk("lat15_cycle", 32'(fc), 32'd17);
    chk("lat1_stray", 32'(valid_b), 32'h1);
    chk("lat15_stray", 32'(valid_c), 32'h1);
    chk("lat1_data", data_b, 32'h1111_1111);
    chk("lat15_data", data_c, 32'h1111_1111);
    ack_b = 2'b01; ack_c = 2'b01;
    tick();
    ack_b = 2'b00; ack_c = 2'b00;
    chk("lat1_ack", 32'(valid_b), 32'd0);
    chk("lat15_ack", 32'(valid_c), 32'd0);

    // Randomized traffic against the reference model.
    pend = 2'b00;
    mb = 0; mt = 0; mo = 0; mrr = 1; msel = 0; mx = 0; mdata = 0;
    for (int it = 0; it < 2000; it++) begin
      eg = (mb && mt == 1) ? (mo ? 2'b10 : 2'b01) : 2'b00;
      ev = (mb && mt >= LM + 2) ? (mo ? 2'b10 : 2'b01) : 2'b00;
      if (it > 0) begin
        chk("r_gnt", 32'(gnt), 32'(eg));
        chk("r_start", 32'(au_start), 32'(eg != 2'b00));
        chk("r_valid", 32'(rsp_valid), 32'(ev));
        chk("r_busy", 32'(busy), 32'(mb));
        chk("r_data", rsp_data, mdata);
        chk("r_au_x", au_x, mx);
        chk("r_au_sel", 32'(au_sel), 32'(msel));
      end
      for (int i = 0; i < 2; i++) begin
        if (eg[i])           pend[i] = 1'b0;
        else if (pend[i])    pend[i] = ($urandom_range(0, 19) != 0);
        else                 pend[i] = ($urandom_range(0, 2) == 0);
      end
      rst = (it == 0) || ($urandom_range(0, 59) == 0);
      req = pend;
      op_sel = 2'($urandom);
      x0 = $urandom; x1 = $urandom;
      rsp_ack = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      model_step(rst, req, op_sel, x0, x1, rsp_ack);
      tick();
    end
    rst = 0; req = 0; rsp_ack = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/act_arbiter.md
ACT_ARBITER -- requirements
Module: act_arbiter

Interface
REQ-001 The module SHALL have parameter LAT, default 2, meaning the activation unit's result latency in cycles after au_start; legal range is 1..15.
REQ-002 The module SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The module SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port req, input, 2 bits: per-requester operation request, held high until granted.
REQ-005 The module SHALL have port op_sel, input, 2 bits: per-requester function select; 0 = sigmoid, 1 = inverse sigmoid.
REQ-006 The module SHALL have ports x0 and x1, input, 32 bits each: IEEE-754 single-precision operands for requesters 0 and 1.
REQ-007 The module SHALL have port gnt, output, 2 bits: one-hot, one-cycle acceptance pulse.
REQ-008 The module SHALL have ports au_x (output, 32 bits), au_sel (output, 1 bit) and au_start (output, 1 bit): operand, function select and start pulse to the shared activation unit.
REQ-009 The module SHALL have ports sig_y and isig_y, input, 32 bits each: results from the sigmoid unit and the inverse-sigmoid unit.
REQ-010 The module SHALL have port rsp_valid, output, 2 bits: one-hot; the result is pending for that requester.
REQ-011 The module SHALL have port rsp_data, output, 32 bits: the result word.
REQ-012 The module SHALL have port rsp_ack, input, 2 bits: per-requester consumption of the result.
REQ-013 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, and all outputs SHALL be registered or Moore-decoded from state.
REQ-015 In IDLE with req != 0, the module SHALL select the owner, latch owner, the operand (x0 or x1) and the select (op_sel[owner]), and move to ISSUE; with req == 0 it SHALL stay in IDLE.
REQ-016 Owner selection SHALL be round-robin: when exactly one request bit is set, that requester wins; when both are set, the requester other than the last-served one (pointer rr) wins.
REQ-017 In ISSUE, for exactly one cycle, the module SHALL assert gnt[owner]=1 and au_start=1, drive au_x and au_sel from the latches, load the 4-bit counter with LAT-1, and move to WAIT.
REQ-018 au_x and au_sel SHALL stay stable from ISSUE through the capture cycle, and SHALL hold their last value elsewhere.
REQ-019 In WAIT, the counter SHALL decrement each cycle.
REQ-020 When the counter is 0 in WAIT, the module SHALL capture rsp_data = (au_sel ? isig_y : sig_y) and move to RESP; WAIT therefore lasts LAT cycles.
REQ-021 Latency: with req sampled in IDLE at cycle 0, gnt and au_start SHALL be high in cycle 1, and rsp_valid SHALL rise in cycle LAT+2.
REQ-022 In RESP, the module SHALL hold rsp_valid[owner]=1 and rsp_data constant until rsp_ack[owner]=1 is sampled.
REQ-023 On that rsp_ack, the module SHALL set rr to owner and go to IDLE, with rsp_valid deasserted in the next cycle.
REQ-024 rsp_ack bits that are not for the current owner, or that arrive outside RESP, SHALL be ignored.
REQ-025 Changes to req, op_sel or x after the IDLE sampling edge SHALL NOT affect the operation in flight.
REQ-026 A requester that drops req before it is granted SHALL NOT receive an operation.
REQ-027 Requests arriving while busy SHALL wait; no request SHALL be lost while req is held.
REQ-028 Minimum back-to-back spacing SHALL be LAT+3 cycles from one gnt to the next: IDLE 1, ISSUE 1, WAIT LAT, RESP ≥1.
REQ-029 Results SHALL be forwarded bit-exact; the module SHALL NOT perform any floating-point interpretation.

Reset
REQ-030 Reset SHALL force state IDLE, rr=1 (so requester 0 wins the first tie), counter=0, gnt=0, au_start=0, au_sel=0, au_x=0, rsp_valid=0, rsp_data=0 and busy=0.
REQ-031 Reset asserted in any state, including mid-WAIT or RESP, SHALL discard the pending operation with no rsp_valid; the requester must re-request.

Verification
REQ-032 Scenario: single op with LAT=2, req=01, op_sel=00, x0=32'h0000_0000, sig_y model returns 32'h3F00_0000 -> gnt=01 in cycle 1, au_x=0, au_sel=0, rsp_valid=01 in cycle 4, rsp_data=32'h3F00_0000, held until rsp_ack=01.
REQ-033 Scenario: inverse select, req=10, op_sel=10, x1=32'h3F00_0000, isig_y=32'h0000_0000 -> au_sel=1, rsp_valid=10, rsp_data=32'h0000_0000.
REQ-034 Scenario: fairness, req=11 held continuously for 4 operations -> grant order 01, 10, 01, 10, with gnt pulses ≥ LAT+3 cycles apart.
REQ-035 Scenario: delayed ack, rsp_ack withheld for 10 cycles while req=10 pending -> rsp_valid and rsp_data stable for all 10 cycles, no gnt, gnt=10 one cycle after leaving RESP plus IDLE.
REQ-036 Scenario: Reset pulsed during WAIT -> all outputs 0 next cycle, no rsp_valid, and the next req=11 grants 01.
REQ-037 Scenario: LAT=1 and LAT=15 builds -> rsp_valid in cycle 3 and cycle 17 respectively; stray rsp_ack=10 while owner=0 is ignored.
